// File: rtl/minmax_pkg.sv
// Shared types and default widths for the streaming min/max tracker.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mm_state_t;

  localparam int BITS_DEF  = 8;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mm_cmp.sv
// Combinational MSB-first priority comparator, signed or unsigned, producing a<b and a==b.
module mm_cmp #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            signed_mode,
  output logic            lt,
  output logic            eq
);

  // The first differing bit from the top decides; in signed mode a set sign bit is the smaller one.
  always_comb begin
    lt = 1'b0;
    eq = 1'b1;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (eq && (a[i] != b[i])) begin
        eq = 1'b0;
        if ((i == BITS - 1) && signed_mode) lt = a[i];
        else                                lt = b[i];
      end
    end
  end

endmodule

// File: rtl/minmax_tracker.sv
// Frame-based running min/max tracker with first-occurrence indices and a saturating beat count.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_last,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_min,
  output logic [BITS-1:0]  out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mm_state_t        state_p0, state_nxt;
  logic             rdy_en_p0;
  logic             mode_p0;
  logic [BITS-1:0]  min_p0, max_p0;
  logic [CNT_W-1:0] min_idx_p0, max_idx_p0, cnt_p0;
  logic             ovf_p0;
  logic             beat;
  logic             lt_min, eq_min, lt_max, eq_max;
  logic             upd_min, upd_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  assign beat = in_valid & in_ready;

  mm_cmp #(.BITS(BITS)) u_cmp_min (
    .a           (in_data),
    .b           (min_p0),
    .signed_mode (mode_p0),
    .lt          (lt_min),
    .eq          (eq_min)
  );

  mm_cmp #(.BITS(BITS)) u_cmp_max (
    .a           (max_p0),
    .b           (in_data),
    .signed_mode (mode_p0),
    .lt          (lt_max),
    .eq          (eq_max)
  );

  // Strictly-better only, so ties keep the earliest index.
  assign upd_min = lt_min & ~eq_min;
  assign upd_max = lt_max & ~eq_max;

  // ---- stage p0: FSM state and ready enable ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0  <= IDLE;
      rdy_en_p0 <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      rdy_en_p0 <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (beat) state_nxt = in_last ? HOLD : ACCUM;
      ACCUM:   if (beat && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p0)
      IDLE, ACCUM: in_ready  = rdy_en_p0;
      HOLD:        out_valid = 1'b1;
      default:     in_ready  = 1'b0;
    endcase
  end

  // ---- stage p0: accumulators; reused directly as the registered result record ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p0    <= 1'b0;
      min_p0     <= '0;
      max_p0     <= '0;
      min_idx_p0 <= '0;
      max_idx_p0 <= '0;
      cnt_p0     <= '0;
      ovf_p0     <= 1'b0;
    end else if (beat) begin
      if (state_p0 == IDLE) begin
        mode_p0    <= signed_mode;
        min_p0     <= in_data;
        max_p0     <= in_data;
        min_idx_p0 <= '0;
        max_idx_p0 <= '0;
        cnt_p0     <= CNT_W'(1);
        ovf_p0     <= 1'b0;
      end else begin
        if (upd_min) begin
          min_p0     <= in_data;
          min_idx_p0 <= cnt_p0;
        end
        if (upd_max) begin
          max_p0     <= in_data;
          max_idx_p0 <= cnt_p0;
        end
        cnt_p0 <= sat_inc(cnt_p0);
        if (cnt_p0 == CNT_MAX) ovf_p0 <= 1'b1;
      end
    end
  end

  assign out_min     = min_p0;
  assign out_max     = max_p0;
  assign out_min_idx = min_idx_p0;
  assign out_max_idx = max_idx_p0;
  assign out_count   = cnt_p0;
  assign out_ovf     = ovf_p0;

endmodule

// File: tb/tb_minmax_tracker.sv
// Randomized bench for minmax_tracker: two instances (8-bit and 2-bit counters) against a frame-level model.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, signed_mode, out_ready;
  logic [7:0] in_data;

  logic       in_ready_a, out_valid_a, ovf_a;
  logic [7:0] min_a, max_a, min_idx_a, max_idx_a, cnt_a;
  logic       in_ready_b, out_valid_b, ovf_b;
  logic [7:0] min_b, max_b;
  logic [1:0] min_idx_b, max_idx_b, cnt_b;

  minmax_tracker #(.BITS(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .signed_mode(signed_mode), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_min(min_a), .out_max(max_a), .out_min_idx(min_idx_a), .out_max_idx(max_idx_a),
    .out_count(cnt_a), .out_ovf(ovf_a)
  );

  minmax_tracker #(.BITS(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .signed_mode(signed_mode), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_min(min_b), .out_max(max_b), .out_min_idx(min_idx_b), .out_max_idx(max_idx_b),
    .out_count(cnt_b), .out_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mn;
    logic [7:0] mx;
    int         mn_i;
    int         mx_i;
    int         cnt;
    bit         ovf;
  } res_t;

  logic [7:0] frame_q[$];
  bit         frame_mode;

  function automatic bit less(input logic [7:0] a, input logic [7:0] b, input bit sm);
    if (sm) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Frame-level expectation: strict compare keeps first occurrence, indices and count clip at cmax.
  function automatic res_t model(input int cmax);
    res_t r;
    int   n;
    n      = frame_q.size();
    r.mn   = frame_q[0];
    r.mx   = frame_q[0];
    r.mn_i = 0;
    r.mx_i = 0;
    for (int i = 1; i < n; i++) begin
      if (less(frame_q[i], r.mn, frame_mode)) begin
        r.mn   = frame_q[i];
        r.mn_i = (i > cmax) ? cmax : i;
      end
      if (less(r.mx, frame_q[i], frame_mode)) begin
        r.mx   = frame_q[i];
        r.mx_i = (i > cmax) ? cmax : i;
      end
    end
    r.cnt = (n > cmax) ? cmax : n;
    r.ovf = (n > cmax);
    return r;
  endfunction

  task automatic check_result(input string tag, input res_t ea, input res_t eb);
    chk({tag, ".a.valid"},   32'(out_valid_a), 32'd1);
    chk({tag, ".a.ready"},   32'(in_ready_a),  32'd0);
    chk({tag, ".a.min"},     32'(min_a),       32'(ea.mn));
    chk({tag, ".a.max"},     32'(max_a),       32'(ea.mx));
    chk({tag, ".a.min_idx"}, 32'(min_idx_a),   32'(ea.mn_i));
    chk({tag, ".a.max_idx"}, 32'(max_idx_a),   32'(ea.mx_i));
    chk({tag, ".a.count"},   32'(cnt_a),       32'(ea.cnt));
    chk({tag, ".a.ovf"},     32'(ovf_a),       32'(ea.ovf));
    chk({tag, ".b.valid"},   32'(out_valid_b), 32'd1);
    chk({tag, ".b.min"},     32'(min_b),       32'(eb.mn));
    chk({tag, ".b.max"},     32'(max_b),       32'(eb.mx));
    chk({tag, ".b.min_idx"}, 32'(min_idx_b),   32'(eb.mn_i));
    chk({tag, ".b.max_idx"}, 32'(max_idx_b),   32'(eb.mx_i));
    chk({tag, ".b.count"},   32'(cnt_b),       32'(eb.cnt));
    chk({tag, ".b.ovf"},     32'(ovf_b),       32'(eb.ovf));
  endtask

  // Presents one beat from a negedge and returns at the negedge after it was taken.
  task automatic send_beat(input logic [7:0] d, input bit last, input bit sm, output bit ok);
    int n = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = last;
    signed_mode = sm;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) chk("ready_timeout", 32'(in_ready_a), 32'd1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input bit sm, input bit gaps);
    bit ok;
    frame_mode = sm;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(frame_q[i], (i == frame_q.size() - 1), (i == 0) ? sm : 1'($urandom), ok);
      if (!ok) return;
    end
  endtask

  task automatic finish_frame(input string tag, input int hold_cyc);
    res_t ea, eb;
    ea = model(255);
    eb = model(3);
    out_ready = 1'b0;
    check_result(tag, ea, eb);
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      check_result({tag, ".hold"}, ea, eb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".taken.valid"}, 32'(out_valid_a), 32'd0);
    chk({tag, ".taken.ready"}, 32'(in_ready_a),  32'd1);
    chk({tag, ".taken.b_valid"}, 32'(out_valid_b), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".valid"},   32'(out_valid_a), 32'd0);
    chk({tag, ".ready"},   32'(in_ready_a),  32'd0);
    chk({tag, ".min"},     32'(min_a),       32'd0);
    chk({tag, ".max"},     32'(max_a),       32'd0);
    chk({tag, ".min_idx"}, 32'(min_idx_a),   32'd0);
    chk({tag, ".max_idx"}, 32'(max_idx_a),   32'd0);
    chk({tag, ".count"},   32'(cnt_a),       32'd0);
    chk({tag, ".ovf"},     32'(ovf_a),       32'd0);
    chk({tag, ".b.count"}, 32'(cnt_b),       32'd0);
  endtask

  initial begin
    bit ok;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_data     = 8'h00;
    signed_mode = 1'b0;
    out_ready   = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("reset.release_ready", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    chk("reset.first_edge_ready", 32'(in_ready_a), 32'd1);

    frame_q = '{8'h05, 8'h01, 8'h09, 8'h01};
    send_frame(1'b0, 1'b0);
    finish_frame("unsigned4", 0);

    frame_q = '{8'h7F, 8'h80, 8'h00};
    send_frame(1'b1, 1'b0);
    finish_frame("signed3", 1);
    send_frame(1'b0, 1'b0);
    finish_frame("signed3_as_unsigned", 0);

    frame_q = '{8'h3C};
    send_frame(1'b0, 1'b0);
    finish_frame("single", 0);

    frame_q = '{8'h10, 8'hF0, 8'h10};
    send_frame(1'b1, 1'b1);
    finish_frame("backpressure", 5);

    frame_q = '{8'h22, 8'h11, 8'h33, 8'h11, 8'h44, 8'h00};
    send_frame(1'b0, 1'b0);
    finish_frame("ovf6", 0);
    frame_q = '{8'h09, 8'h08};
    send_frame(1'b0, 1'b0);
    finish_frame("after_ovf", 0);

    send_beat(8'h55, 1'b0, 1'b0, ok);
    send_beat(8'h66, 1'b0, 1'b0, ok);
    rst = 1'b1;
    #1 check_cleared("mid_accum_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_q = '{8'h02, 8'h04};
    send_frame(1'b0, 1'b0);
    finish_frame("post_rst", 0);

    frame_q = '{8'hA0, 8'h0A};
    send_frame(1'b0, 1'b0);
    rst = 1'b1;
    #1 check_cleared("mid_hold_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    frame_q.delete();
    for (int i = 0; i < 300; i++) frame_q.push_back(8'($urandom));
    send_frame(1'b1, 1'b0);
    finish_frame("long300", 2);

    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 10);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) frame_q.push_back(8'($urandom_range(0, 3)));
        else if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom_range(126, 129)));
        else frame_q.push_back(8'($urandom));
      end
      send_frame(1'($urandom), 1'($urandom));
      finish_frame($sformatf("rand%0d", f), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
